// File: rtl/ser10b_pkg.sv
// Shared constants and helpers for the 8b/10b serializer.
// The optional disparity check is enabled with SER10B_DISP_CHECK_EN.
package ser10b_pkg;

  localparam int WORD_W = 10;
  localparam int CNT_W  = 4;

  localparam logic [WORD_W-1:0] COMMA_RDN = 10'b0011111010;
  localparam logic [WORD_W-1:0] COMMA_RDP = 10'b1100000101;
  localparam logic [CNT_W-1:0]  LAST_BIT  = 4'd9;

  function automatic logic [3:0] ones10(input logic [WORD_W-1:0] group);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < WORD_W; i++) begin
      cnt = cnt + {3'b000, group[i]};
    end
    return cnt;
  endfunction

  // Balanced and illegal groups leave the running disparity where it was.
  function automatic logic rd_next(input logic rd, input logic [WORD_W-1:0] group);
    logic [3:0] n;
    logic       rd_out;
    n = ones10(group);
    if (n == 4'd6) begin
      rd_out = 1'b1;
    end else if (n == 4'd4) begin
      rd_out = 1'b0;
    end else begin
      rd_out = rd;
    end
    return rd_out;
  endfunction

endpackage

// File: rtl/ser10b_rd_tracker.sv
// Running-disparity register for the serializer, plus the optional
// disparity check compiled in with SER10B_DISP_CHECK_EN.
module ser10b_rd_tracker
  import ser10b_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              is_data,
  input  logic [WORD_W-1:0] group,
  output logic              rd_pos,
  output logic              disp_err
);

  logic rd_pos_reg;

  // Reset value is the RD left behind by the COMMA_RDN sent out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pos_reg <= 1'b1;
    end else if (load) begin
      rd_pos_reg <= rd_next(rd_pos_reg, group);
    end
  end

  assign rd_pos = rd_pos_reg;

`ifdef SER10B_DISP_CHECK_EN
  logic [3:0] ones_cnt;
  logic       bad_group;
  logic       disp_err_reg;

  always_comb begin
    ones_cnt  = ones10(group);
    bad_group = (ones_cnt < 4'd4) || (ones_cnt > 4'd6) ||
                ((ones_cnt == 4'd6) && rd_pos_reg) ||
                ((ones_cnt == 4'd4) && !rd_pos_reg);
  end

  // One-cycle pulse aligned with the first bit of the offending word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_err_reg <= 1'b0;
    end else begin
      disp_err_reg <= load && is_data && bad_group;
    end
  end

  assign disp_err = disp_err_reg;
`else
  logic unused_is_data;
  assign unused_is_data = is_data;
  assign disp_err       = 1'b0;
`endif

endmodule

// File: rtl/ser10b_tx.sv
// 10-bit code-group serializer with one-entry holding register and
// K28.5 idle fill. Optional disparity check: SER10B_DISP_CHECK_EN.
module ser10b_tx #(
  parameter int WORD_W = ser10b_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              word_start,
  output logic              tx_is_comma,
  output logic              rd_pos,
  output logic              disp_err
);
  import ser10b_pkg::*;

  if (WORD_W != 10) begin : g_width_check
    $error("ser10b_tx: WORD_W must be 10 for 8b/10b code groups");
  end

  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] hold_reg;
  logic [WORD_W-1:0] load_group;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              hold_full_reg;
  logic              word_start_reg;
  logic              tx_is_comma_reg;
  logic              at_boundary;
  logic              accept;

  assign at_boundary = (bit_cnt_reg == LAST_BIT);
  assign accept      = in_valid && !hold_full_reg;
  // Comma polarity follows the RD left by the group now on the line.
  assign load_group  = hold_full_reg ? hold_reg : (rd_pos ? COMMA_RDP : COMMA_RDN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg       <= COMMA_RDN;
      bit_cnt_reg     <= '0;
      word_start_reg  <= 1'b1;
      tx_is_comma_reg <= 1'b1;
      hold_full_reg   <= 1'b0;
      hold_reg        <= '0;
    end else begin
      if (at_boundary) begin
        shift_reg       <= load_group;
        bit_cnt_reg     <= '0;
        tx_is_comma_reg <= !hold_full_reg;
      end else begin
        shift_reg   <= {shift_reg[WORD_W-2:0], 1'b0};
        bit_cnt_reg <= bit_cnt_reg + 4'd1;
      end
      word_start_reg <= at_boundary;
      // An accept can only happen while empty, so it never races the drain.
      if (accept) begin
        hold_full_reg <= 1'b1;
        hold_reg      <= data_in;
      end else if (at_boundary) begin
        hold_full_reg <= 1'b0;
      end
    end
  end

  ser10b_rd_tracker u_rd_tracker (
    .clk      (clk),
    .reset    (reset),
    .load     (at_boundary),
    .is_data  (hold_full_reg),
    .group    (load_group),
    .rd_pos   (rd_pos),
    .disp_err (disp_err)
  );

  assign in_ready    = !hold_full_reg;
  assign tx_bit      = shift_reg[WORD_W-1];
  assign word_start  = word_start_reg;
  assign tx_is_comma = tx_is_comma_reg;

endmodule

// File: tb/tb_ser10b_tx.sv
// Scoreboard bench for ser10b_tx: expected groups are queued as words are
// accepted and compared as each 10-bit group leaves the serializer.
module tb_ser10b_tx;

  localparam logic [9:0] RDN_G = 10'b0011111010;
  localparam logic [9:0] RDP_G = 10'b1100000101;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] data_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, tx_bit, word_start, tx_is_comma, rd_pos, disp_err;

  always #5 clk = ~clk;

  ser10b_tx dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tx_bit      (tx_bit),
    .word_start  (word_start),
    .tx_is_comma (tx_is_comma),
    .rd_pos      (rd_pos),
    .disp_err    (disp_err)
  );

  typedef struct packed {
    logic [9:0] group;
    logic       comma;
    logic       rd;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] word_q[$];
  exp_t       cur;
  int         checks = 0;
  int         errors = 0;
  int         cnt_m = 0;
  logic       rd_m = 1'b1;
  logic [9:0] obs_bits, obs_ws, obs_comma, obs_err;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t predict(input logic [9:0] g, input logic is_comma, input logic rd_before);
    int   n;
    exp_t e;
    n       = $countones(g);
    e.group = g;
    e.comma = is_comma;
    e.rd    = (n == 6) ? 1'b1 : ((n == 4) ? 1'b0 : rd_before);
    e.err   = 1'b0;
`ifdef SER10B_DISP_CHECK_EN
    if (!is_comma)
      e.err = (n < 4) || (n > 6) || (n == 6 && rd_before) || (n == 4 && !rd_before);
`endif
    return e;
  endfunction

  task automatic check_reset(input string p);
    check_value({p, "_tx_bit"}, tx_bit, 1'b0);
    check_value({p, "_word_start"}, word_start, 1'b1);
    check_value({p, "_tx_is_comma"}, tx_is_comma, 1'b1);
    check_value({p, "_rd_pos"}, rd_pos, 1'b1);
    check_value({p, "_in_ready"}, in_ready, 1'b1);
    check_value({p, "_disp_err"}, disp_err, 1'b0);
  endtask

  task automatic sample();
    if (cnt_m == 0) begin
      if (exp_q.size() == 0) check_value("exp_q_underflow", 1, 0);
      else cur = exp_q.pop_front();
      check_value("rd_pos", rd_pos, cur.rd);
    end
    obs_bits  = {obs_bits[8:0], tx_bit};
    obs_ws    = {obs_ws[8:0], word_start};
    obs_comma = {obs_comma[8:0], tx_is_comma};
    obs_err   = {obs_err[8:0], disp_err};
    check_value("in_ready", in_ready, word_q.size() == 0);
    if (cnt_m == 9) begin
      check_value("group_bits", obs_bits, cur.group);
      check_value("word_start", obs_ws, 10'b1000000000);
      check_value("tx_is_comma", obs_comma, {10{cur.comma}});
      check_value("disp_err", obs_err, {cur.err, 9'b0});
      $display("group %b comma=%b rd=%b err=%b", obs_bits, cur.comma, cur.rd, cur.err);
    end
  endtask

  // Advance one clock: model the edge, then sample on the next falling edge.
  task automatic cycle();
    logic acc;
    acc = in_valid && in_ready;
    if (cnt_m == 9) begin
      if (word_q.size() > 0) exp_q.push_back(predict(word_q.pop_front(), 1'b0, rd_m));
      else exp_q.push_back(predict(rd_m ? RDP_G : RDN_G, 1'b1, rd_m));
      rd_m  = exp_q[$].rd;
      cnt_m = 0;
    end else begin
      cnt_m++;
    end
    if (acc) word_q.push_back(data_in);
    @(negedge clk);
    sample();
  endtask

  task automatic release_reset();
    word_q.delete();
    exp_q.delete();
    exp_q.push_back(predict(RDN_G, 1'b1, 1'b1));
    rd_m  = 1'b1;
    cnt_m = 0;
    reset = 1'b1;
    sample();
  endtask

  task automatic send_word(input logic [9:0] w, input int at_cnt, input int need_rd, input bit keep);
    int guard;
    bit acc;
    guard = 0;
    if (!in_valid) begin
      while (!((at_cnt < 0 || cnt_m == at_cnt) && (need_rd < 0 || rd_m == need_rd[0]) && in_ready)
             && guard < 200) begin
        cycle();
        guard++;
      end
      if (guard >= 200) check_value("wait_slot_timeout", 1, 0);
    end
    data_in  = w;
    in_valid = 1'b1;
    guard    = 0;
    do begin
      acc = in_ready;
      cycle();
      guard++;
    end while (!acc && guard < 40);
    if (!acc) check_value("accept_timeout", 0, 1);
    if (!keep) in_valid = 1'b0;
  endtask

  initial begin
    int guard;
    // Idle stream out of reset.
    repeat (3) @(negedge clk);
    check_reset("reset");
    release_reset();
    repeat (40) cycle();

    // Single balanced word accepted mid-group.
    send_word(10'b1111100000, 3, -1, 0);
    repeat (20) cycle();

    // Back-to-back words starting at RD-, in_valid held high.
    send_word(10'b1110101100, -1, 0, 1);
    send_word(10'b0001010011, -1, -1, 0);
    repeat (25) cycle();

    // Accept on the load boundary: comma first, word next group.
    send_word(10'b1010110010, 9, -1, 0);
    repeat (25) cycle();

    // Disparity-error cases.
    send_word(10'b1111110000, 2, 1, 0);
    send_word(10'b1100010000, 2, -1, 0);
    repeat (20) cycle();

    // A few random words with random gaps.
    for (int k = 0; k < 6; k++) begin
      send_word(10'($urandom_range(0, 1023)), int'($urandom_range(0, 9)), -1, 0);
      repeat ($urandom_range(0, 12)) cycle();
    end
    repeat (25) cycle();

    // Mid-word reset with a word held.
    send_word(10'b0101010101, 2, -1, 0);
    guard = 0;
    while (cnt_m != 5 && guard < 20) begin
      cycle();
      guard++;
    end
    check_value("held_before_reset", in_ready, 1'b0);
    #2 reset = 1'b0;
    #1 check_reset("midreset");
    @(negedge clk);
    @(negedge clk);
    release_reset();
    repeat (30) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
